// File: rtl/btn_cmd_pkg.sv
// Shared command/key definitions for the button command queue and the game FSM decoder.
package btn_cmd_pkg;

  localparam int CMD_W = 3;
  localparam int KEY_N = 5;

  localparam logic [CMD_W-1:0] CMD_NONE  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd2;
  localparam logic [CMD_W-1:0] CMD_ROT   = 3'd3;
  localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd4;
  localparam logic [CMD_W-1:0] CMD_DROP  = 3'd5;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_ROT   = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_DROP  = 4;

  // One-hot pick of the most urgent pending key: DROP > ROT > LEFT > RIGHT > DOWN.
  function automatic logic [KEY_N-1:0] prio_grant(input logic [KEY_N-1:0] req);
    logic [KEY_N-1:0] g;
    g = {KEY_N{1'b0}};
    if (req[KEY_DROP])       g[KEY_DROP]  = 1'b1;
    else if (req[KEY_ROT])   g[KEY_ROT]   = 1'b1;
    else if (req[KEY_LEFT])  g[KEY_LEFT]  = 1'b1;
    else if (req[KEY_RIGHT]) g[KEY_RIGHT] = 1'b1;
    else if (req[KEY_DOWN])  g[KEY_DOWN]  = 1'b1;
    else                     g = {KEY_N{1'b0}};
    return g;
  endfunction

  function automatic logic [CMD_W-1:0] grant_code(input logic [KEY_N-1:0] g);
    logic [CMD_W-1:0] c;
    if (g[KEY_DROP])       c = CMD_DROP;
    else if (g[KEY_ROT])   c = CMD_ROT;
    else if (g[KEY_LEFT])  c = CMD_LEFT;
    else if (g[KEY_RIGHT]) c = CMD_RIGHT;
    else if (g[KEY_DOWN])  c = CMD_DOWN;
    else                   c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with flush; head valid/code are registered so they
// already reflect a push into an empty queue on the same edge.
module cmd_fifo
  import btn_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_code,
  input  logic             pop,
  input  logic             flush,
  output logic [AW:0]      count,
  output logic             head_valid,
  output logic [CMD_W-1:0] head_code
);

  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0] CNT_0   = (AW+1)'(0);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             valid_q, valid_d;
  logic [CMD_W-1:0] code_q, code_d;
  logic             push_s, pop_s;

  // Next-state for storage, pointers, occupancy and the registered head.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    pop_s   = pop && (count_q != CNT_0);
    push_s  = push && ((count_q < FULL) || pop_s);
    if (flush) begin
      wr_d    = {AW{1'b0}};
      rd_d    = {AW{1'b0}};
      count_d = CNT_0;
    end else begin
      if (push_s) begin
        mem_d[wr_q] = push_code;
        wr_d        = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    valid_d = (count_d != CNT_0);
    code_d  = valid_d ? mem_d[rd_d] : CMD_NONE;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= CMD_NONE;
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= CNT_0;
      valid_q <= 1'b0;
      code_q  <= CMD_NONE;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign count      = count_q;
  assign head_valid = valid_q;
  assign head_code  = code_q;

endmodule

// File: rtl/btn_cmd_queue.sv
// Turns debounced key press pulses into an ordered, priority-serialised command
// stream with a sticky flag for presses that had to be merged.
module btn_cmd_queue
  import btn_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_rot,
  input  logic             key_down,
  input  logic             key_drop,
  input  logic             flush,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_code,
  input  logic             cmd_ready,
  output logic [AW:0]      cmd_count,
  output logic             evt_lost
);

  logic [KEY_N-1:0] pend_q, pend_d;
  logic             evt_lost_q, evt_lost_d;
  logic [KEY_N-1:0] pulse_s, grant_s;
  logic             pop_s, push_ok_s, push_s;
  logic [CMD_W-1:0] push_code_s;

  // Grant one pending key per cycle when the FIFO can take it; track merges.
  always_comb begin
    pulse_s     = {key_drop, key_down, key_rot, key_right, key_left};
    pop_s       = cmd_valid && cmd_ready && !flush;
    push_ok_s   = (cmd_count < (AW+1)'(DEPTH)) || pop_s;
    grant_s     = (push_ok_s && !flush) ? prio_grant(pend_q) : {KEY_N{1'b0}};
    push_s      = |grant_s;
    push_code_s = grant_code(grant_s);
    if (flush) begin
      pend_d     = {KEY_N{1'b0}};
      evt_lost_d = 1'b0;
    end else begin
      pend_d     = (pend_q & ~grant_s) | pulse_s;
      evt_lost_d = evt_lost_q | (|(pulse_s & pend_q & ~grant_s));
    end
  end

  // Pending latch and sticky loss flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= {KEY_N{1'b0}};
      evt_lost_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      evt_lost_q <= evt_lost_d;
    end
  end

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_code  (push_code_s),
    .pop        (pop_s),
    .flush      (flush),
    .count      (cmd_count),
    .head_valid (cmd_valid),
    .head_code  (cmd_code)
  );

  assign evt_lost = evt_lost_q;

endmodule

// File: tb/tb_btn_cmd_queue.sv
// Scoreboard bench for btn_cmd_queue: a queue-based reference model predicts
// every command; a negedge monitor checks the DUT head, count and loss flag.
module tb_btn_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_rot = 1'b0;
  logic       key_down = 1'b0, key_drop = 1'b0;
  logic       flush = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [2:0] cmd_count;
  logic       evt_lost;

  always #5 clk = ~clk;

  btn_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_left  (key_left),
    .key_right (key_right),
    .key_rot   (key_rot),
    .key_down  (key_down),
    .key_drop  (key_drop),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .evt_lost  (evt_lost)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: key index k (LEFT=0..DROP=4) maps to command code k+1.
  int exp_q[$];
  bit pend_m[5];
  bit lost_m = 1'b0;
  int prio[5] = '{4, 2, 0, 1, 3};

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 5; i++) pend_m[i] = 1'b0;
    lost_m = 1'b0;
  endtask

  task automatic model_step();
    bit p[5];
    bit done;
    p[0] = key_left; p[1] = key_right; p[2] = key_rot; p[3] = key_down; p[4] = key_drop;
    if (flush) begin
      model_clear();
    end else begin
      // exp_q already had this cycle's pop removed by the monitor.
      done = 1'b0;
      if (exp_q.size() < DEPTH) begin
        for (int i = 0; i < 5; i++) begin
          if (!done && pend_m[prio[i]]) begin
            exp_q.push_back(prio[i] + 1);
            pend_m[prio[i]] = 1'b0;
            done = 1'b1;
          end
        end
      end
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          if (pend_m[k]) lost_m = 1'b1;
          pend_m[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // Monitor: compare DUT outputs mid-cycle, retire the head on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid", int'(cmd_valid), int'(exp_q.size() != 0));
      chk("count", int'(cmd_count), exp_q.size());
      chk("lost", int'(evt_lost), int'(lost_m));
      if (exp_q.size() != 0) begin
        chk("head_code", int'(cmd_code), exp_q[0]);
        if (rst_n && cmd_ready && !flush) void'(exp_q.pop_front());
      end else begin
        chk("idle_code", int'(cmd_code), 0);
      end
    end
  end

  task automatic step(input logic [4:0] k, input logic rdy, input logic fl);
    {key_drop, key_down, key_rot, key_right, key_left} = k;
    cmd_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #2;
    {key_drop, key_down, key_rot, key_right, key_left} = 5'b00000;
    flush = 1'b0;
  endtask

  initial begin
    logic [4:0] k;
    // Pulses during reset must be ignored.
    key_rot = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    key_rot = 1'b0;
    rst_n   = 1'b1;
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_count", int'(cmd_count), 0);
    step(5'b00000, 1'b1, 1'b0);
    chk("reset_ignored", int'(cmd_valid), 0);

    // Single press, two-clock latency, one-cycle visibility with ready high.
    step(5'b00100, 1'b1, 1'b0);
    chk("single_lat1", int'(cmd_valid), 0);
    step(5'b00000, 1'b1, 1'b0);
    chk("single_valid", int'(cmd_valid), 1);
    chk("single_code", int'(cmd_code), 3);
    step(5'b00000, 1'b1, 1'b0);
    chk("single_drained", int'(cmd_count), 0);
    chk("single_lost", int'(evt_lost), 0);

    // LEFT+DOWN+DROP together: serialised as 5,1,4.
    step(5'b11001, 1'b0, 1'b0);
    repeat (3) step(5'b00000, 1'b0, 1'b0);
    chk("simul_count", int'(cmd_count), 3);
    chk("simul_head", int'(cmd_code), 5);
    repeat (4) step(5'b00000, 1'b1, 1'b0);
    chk("simul_drained", int'(cmd_count), 0);

    // Fill, hold RIGHT while full, re-pulse sets lost, pop+push at full.
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00100, 1'b0, 1'b0);
    step(5'b01000, 1'b0, 1'b0);
    step(5'b10000, 1'b0, 1'b0);
    repeat (2) step(5'b00000, 1'b0, 1'b0);
    chk("full_count", int'(cmd_count), 4);
    step(5'b00010, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    chk("held_count", int'(cmd_count), 4);
    chk("held_nolost", int'(evt_lost), 0);
    step(5'b00010, 1'b0, 1'b0);
    chk("repulse_lost", int'(evt_lost), 1);
    step(5'b00000, 1'b1, 1'b0);
    chk("popush_count", int'(cmd_count), 4);
    chk("popush_head", int'(cmd_code), 3);
    repeat (6) step(5'b00000, 1'b1, 1'b0);
    chk("overflow_drained", int'(cmd_count), 0);
    chk("lost_sticky", int'(evt_lost), 1);

    // Flush clears lost and the queue; the LEFT pulsed with it is discarded.
    step(5'b00000, 1'b0, 1'b1);
    chk("flush_lost", int'(evt_lost), 0);
    step(5'b01011, 1'b0, 1'b0);
    repeat (3) step(5'b00000, 1'b0, 1'b0);
    chk("preflush_count", int'(cmd_count), 3);
    step(5'b00001, 1'b1, 1'b1);
    chk("flush_valid", int'(cmd_valid), 0);
    chk("flush_count", int'(cmd_count), 0);
    repeat (4) step(5'b00000, 1'b1, 1'b0);
    chk("flush_no_left", int'(cmd_valid), 0);

    // Asynchronous reset between edges with two queued.
    step(5'b00011, 1'b0, 1'b0);
    repeat (2) step(5'b00000, 1'b0, 1'b0);
    chk("prereset_count", int'(cmd_count), 2);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("arst_valid", int'(cmd_valid), 0);
    chk("arst_count", int'(cmd_count), 0);
    chk("arst_code", int'(cmd_code), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(5'b01000, 1'b0, 1'b0);
    chk("postrst_lat1", int'(cmd_valid), 0);
    step(5'b00000, 1'b0, 1'b0);
    chk("postrst_valid", int'(cmd_valid), 1);
    chk("postrst_code", int'(cmd_code), 4);
    step(5'b00000, 1'b1, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      k = 5'($urandom & $urandom);
      step(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    end
    repeat (20) step(5'b00000, 1'b1, 1'b0);
    chk("final_drained", int'(cmd_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_cmd_queue.md
Name: btn_cmd_queue

Overview:
- Consumer end of the button debouncers: collects one-cycle press pulses from the five debounced game buttons and converts them into an ordered queue of Tetris move commands.
- Commands are presented to the game-logic FSM over a valid/ready handshake.
- Simultaneous presses are serialised by fixed priority. Presses are never dropped silently: any lost press raises a sticky flag.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, minimum 2
AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_left  input  1  one-cycle press pulse, move left
key_right  input  1  one-cycle press pulse, move right
key_rot  input  1  one-cycle press pulse, rotate
key_down  input  1  one-cycle press pulse, soft drop one row
key_drop  input  1  one-cycle press pulse, hard drop
flush  input  1  synchronous clear of the queue (new game / game over)
cmd_valid  output  1  head command available
cmd_code  output  3  head command code
cmd_ready  input  1  game FSM accepts head command
cmd_count  output  AW+1  number of commands queued
evt_lost  output  1  sticky: a press was merged or discarded

Behaviour:
- Reset (rst_n low, asynchronous) clears everything:
  - pend=0, FIFO empty, cmd_valid=0, cmd_code=0, cmd_count=0, evt_lost=0.
  - Pulses seen during reset are ignored.
- Command codes: NONE=0, LEFT=1, RIGHT=2, ROT=3, DOWN=4, DROP=5. Codes 6 and 7 are never produced.
- Pending latch pend[4:0], one bit per key, updated each clock as pend <= (pend & ~grant) | pulses.
  - A pulse arriving in the same cycle its own bit is granted re-sets the bit. It counts as a new event, not a loss.
  - A pulse on a bit that is already set and not being granted is merged, and evt_lost is set.
- Grant logic:
  - push_ok = (cmd_count < DEPTH) || pop.
  - When push_ok and pend != 0, exactly one bit is granted per cycle.
  - Priority: DROP > ROT > LEFT > RIGHT > DOWN.
  - The granted code is written at wr_ptr and wr_ptr increments.
- Pop: pop = cmd_valid && cmd_ready; rd_ptr increments.
- Pointers are AW bits wide and wrap modulo DEPTH.
- cmd_count:
  - +1 on push only, -1 on pop only, unchanged when push and pop occur together.
  - Never exceeds DEPTH and never underflows.
- Outputs:
  - cmd_valid = (cmd_count != 0).
  - cmd_code = mem[rd_ptr] when valid, else 0.
  - cmd_code must stay stable while cmd_valid && !cmd_ready.
- Latency (queue empty, no contention):
  - Pulse sampled at edge N sets pend; push happens at edge N+1; cmd_valid is high after edge N+1.
  - Two clocks from pulse to cmd_valid.
- FIFO full: pending bits are held (not lost) until space frees. Only re-pulses on held bits set evt_lost.
- Full with pop in the same cycle: push is allowed and cmd_count stays at DEPTH.
- flush (synchronous, highest priority):
  - Next edge clears pend, pointers, cmd_count and evt_lost.
  - Key pulses and any pop in the flush cycle are discarded, and evt_lost is not set by them.
  - cmd_valid=0 after the edge.
- evt_lost clears only on flush or reset.
- Inputs are already synchronous one-cycle pulses from the debouncers; no extra synchronisation or edge detection is done here.

Decomposition:
- Shared package btn_cmd_pkg holds:
  - CMD_W=3 and the CMD_NONE..CMD_DROP localparams.
  - Key index constants KEY_LEFT..KEY_DROP (0..4), shared with the game FSM decoder.
- One sub-module, cmd_fifo: a synchronous DEPTH x CMD_W FIFO with push/pop/flush, count, and head output.
- Pending latch and priority grant stay in the top level.

Test Plan:
- Single press: key_rot pulse at cycle 10, cmd_ready=1 → cmd_valid high cycles 12..12, cmd_code=3, cmd_count back to 0, evt_lost=0.
- Simultaneous press: key_left, key_drop and key_down pulsed together, cmd_ready=0 → queue holds 5,1,4 in that order; cmd_count reaches 3 on cycle +4; popping yields 5, then 1, then 4.
- Overflow hold: DEPTH=4 and cmd_ready=0.
  - Push 4 commands, then pulse key_right → pend[right] held, cmd_count=4, evt_lost=0.
  - Pulse key_right again → evt_lost=1.
  - Set cmd_ready=1 → exactly one RIGHT (code 2) follows the original four.
- Full with simultaneous pop/push: count=4, a pending bit, and cmd_ready=1 for one cycle → count stays 4, head advances, new code appears at the tail.
- Flush mid-operation: 3 queued, key_left pulsed on the flush cycle → next cycle cmd_valid=0, cmd_count=0, evt_lost=0, no LEFT ever emitted.
- Async reset mid-stream: drop rst_n between clock edges with 2 queued → outputs go to 0 immediately without a clock; after release a new key_down pulse yields code 4 with 2-cycle latency.
